// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if
//   Output side of the UART receive engine: held word, its error flags,
//   the valid/ready handshake and the overrun / idle-timeout pulses.
//   master : the receive engine (drives data, flags and pulses; reads rx_ready)
//   slave  : the consumer, e.g. RX FIFO or APB register block (drives rx_ready)
interface uart_rx_engine_if #(
  parameter int unsigned DATA_MAX = 8
);
  logic [DATA_MAX-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                parity_err;
  logic                frame_err;
  logic                break_det;
  logic                overrun;
  logic                timeout_flag;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun, timeout_flag,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun, timeout_flag,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   Oversampled UART receiver with majority-vote bit recovery, configurable
//   frame format (5..DATA_MAX data bits, none/even/odd parity, 1 or 2 stop
//   bits), parity/framing/break classification, a valid/ready output register
//   with overrun detection and an idle timeout.
// Ports:
//   PCLK, PRESET    clock, synchronous active-high reset
//   baud_tick       oversample enable, OVERSAMPLE pulses per bit period
//   rx_en           receiver enable; low aborts any frame in progress
//   rxd             asynchronous serial input, idle high
//   data_bits, parity_en, parity_odd, stop_bit_twice
//                   frame format, latched at start-bit detection
//   busy            receive state machine is not idle
//   rx_if           output word/flags and handshake (master modport)
module uart_rx_engine #(
  parameter int unsigned DATA_MAX     = 8,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       baud_tick,
  input  logic       rx_en,
  input  logic       rxd,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop_bit_twice,
  output logic       busy,
  uart_rx_engine_if.master rx_if
);

  localparam int unsigned TW       = $clog2(OVERSAMPLE);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned TOW      = $clog2(TO_LIMIT + 1);

  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP_0, S_STOP_1, S_BRK_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic                r_sync1, r_sync2, r_prev;
  logic [TW-1:0]       r_tick_cnt;
  logic                r_s0, r_s1;
  logic [3:0]          r_bit_cnt;
  logic [DATA_MAX-1:0] r_shift;
  logic                r_par, r_zero, r_perr;
  logic [3:0]          r_len;
  logic                r_par_en, r_par_odd, r_two_stop;

  logic [DATA_MAX-1:0] r_data;
  logic                r_valid, r_perr_o, r_ferr_o, r_brk_o, r_overrun, r_timeout;
  logic [TOW-1:0]      r_to_cnt;

  logic       w_maj, w_dec, w_end, w_start, w_hs;
  logic       w_complete, w_ferr, w_brk;
  logic [3:0] w_len;

  // Majority of the two stored mid-bit samples and the live one.
  assign w_maj   = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_dec   = baud_tick && (r_tick_cnt == T_DEC);
  assign w_end   = baud_tick && (r_tick_cnt == T_END);
  // Falling edge judged at tick rate so a short low between ticks is not lost.
  assign w_start = baud_tick && rx_en && (r_state == S_IDLE) && r_prev && !r_sync2;
  assign w_hs    = r_valid && rx_if.rx_ready;

  assign w_len = (data_bits < 4'd5)           ? 4'd5 :
                 (data_bits > 4'(DATA_MAX))   ? 4'(DATA_MAX) : data_bits;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_ferr      = 1'b0;
    w_brk       = 1'b0;
    if (!rx_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_start) w_state_nxt = S_START;
        S_START: begin
          if (w_dec && w_maj) w_state_nxt = S_IDLE;
          else if (w_end)     w_state_nxt = S_DATA;
        end
        S_DATA: begin
          if (w_end && (r_bit_cnt == r_len - 4'd1))
            w_state_nxt = r_par_en ? S_PARITY : S_STOP_0;
        end
        S_PARITY: if (w_end) w_state_nxt = S_STOP_0;
        S_STOP_0: begin
          if (w_dec) begin
            if (!w_maj) begin
              w_complete  = 1'b1;
              w_ferr      = 1'b1;
              w_brk       = r_zero;
              w_state_nxt = S_BRK_WAIT;
            end else if (!r_two_stop) begin
              w_complete  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else if (w_end && r_two_stop) begin
            w_state_nxt = S_STOP_1;
          end
        end
        S_STOP_1: begin
          if (w_dec) begin
            w_complete  = 1'b1;
            w_ferr      = !w_maj;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK_WAIT: if (baud_tick && r_sync2) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_prev     <= 1'b1;
      r_tick_cnt <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_zero     <= 1'b0;
      r_perr     <= 1'b0;
      r_len      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
    end else begin
      if (baud_tick) r_prev <= r_sync2;
      if (w_start) begin
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_par      <= 1'b0;
        r_zero     <= 1'b1;
        r_perr     <= 1'b0;
        r_len      <= w_len;
        r_par_en   <= parity_en;
        r_par_odd  <= parity_odd;
        r_two_stop <= stop_bit_twice;
      end else if (baud_tick && (r_state != S_IDLE)) begin
        r_tick_cnt <= (r_tick_cnt == T_END) ? '0 : r_tick_cnt + TW'(1);
        if (r_tick_cnt == T_S0) r_s0 <= r_sync2;
        if (r_tick_cnt == T_S1) r_s1 <= r_sync2;
        if (w_dec && (r_state == S_DATA)) begin
          for (int unsigned i = 0; i < DATA_MAX; i++)
            if (r_bit_cnt == 4'(i)) r_shift[i] <= w_maj;
          r_par  <= r_par ^ w_maj;
          r_zero <= r_zero & !w_maj;
        end
        if (w_dec && (r_state == S_PARITY)) begin
          // XOR over data+parity must equal 1 in odd mode, 0 in even mode.
          r_perr <= r_par ^ w_maj ^ r_par_odd;
          r_zero <= r_zero & !w_maj;
        end
        if (w_end && (r_state == S_DATA)) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_brk_o   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      if (w_complete) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data   <= r_shift;
          r_perr_o <= r_perr;
          r_ferr_o <= w_ferr;
          r_brk_o  <= w_brk;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid  <= 1'b0;
        r_perr_o <= 1'b0;
        r_ferr_o <= 1'b0;
        r_brk_o  <= 1'b0;
      end

      // Counter saturates at the limit so the flag fires once per held word.
      if (w_start || w_hs || !r_valid) begin
        r_to_cnt <= '0;
      end else if (baud_tick && (r_state == S_IDLE) && (r_to_cnt != TOW'(TO_LIMIT))) begin
        r_to_cnt <= r_to_cnt + TOW'(1);
        if (r_to_cnt == TOW'(TO_LIMIT - 1)) r_timeout <= 1'b1;
      end
    end
  end

  assign rx_if.rx_data      = r_data;
  assign rx_if.rx_valid     = r_valid;
  assign rx_if.parity_err   = r_perr_o;
  assign rx_if.frame_err    = r_ferr_o;
  assign rx_if.break_det    = r_brk_o;
  assign rx_if.overrun      = r_overrun;
  assign rx_if.timeout_flag = r_timeout;

endmodule
